// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Data-hazard controller for the ID stage of a classic 5-stage MIPS pipeline.
// It keeps a small shadow copy of the register writers that are in flight in
// EX, MEM and WB. It compares them against the source registers of the
// instruction in ID and produces:
//   - a stall that freezes PC and IF/ID,
//   - a bubble that clears ID/EX,
//   - registered EX-stage forwarding selects (forwarding build only),
//   - saturating stall statistics.
//
// Build option:
//   HAZARD_FORWARDING_EN  defined   -> forwarding mode. Only a load followed
//                                      by a use of its result stalls.
//                                      fwd_a/fwd_b are driven.
//                         undefined -> non-forwarding mode. Any EX or MEM
//                                      writer match stalls. fwd_a/fwd_b are
//                                      tied to 0 and no registers are built
//                                      for them.
//
// Parameters:
//   CNT_W          width of the statistics counters
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   id_valid       ID stage holds a real instruction
//   id_rs, id_rt   source register fields of the ID instruction
//   r1_used        ID instruction reads rs
//   r2_used        ID instruction reads rt
//   id_reg_write   ID instruction writes a register
//   id_dest        destination register of the ID instruction (rd/rt muxed)
//   id_mem_to_reg  ID instruction is a load
//   flush          redirect; the ID instruction is discarded
//   stall          hold PC and IF/ID (combinational)
//   bubble         clear ID/EX this cycle (combinational)
//   fwd_a, fwd_b   EX operand selects: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   stall_cycles   number of stalled cycles, saturating
//   stall_events   number of stall rising edges, saturating
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             r1_used,
    input  logic             r2_used,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dest,
    input  logic             id_mem_to_reg,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_events
);

    // One shadow pipeline slot: who will write which register, and whether
    // the value only becomes available after the memory stage.
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_t ex_slot;
    slot_t mem_slot;
    slot_t wb_slot;
    slot_t ex_next;

    logic  src_a_live;
    logic  src_b_live;
    logic  ex_writer;
    logic  mem_writer;
    logic  match_ex_a;
    logic  match_ex_b;
    logic  match_mem_a;
    logic  match_mem_b;
    logic  hazard;
    logic  prev_stall;

    // The WB slot is kept so the shadow pipeline mirrors the real one. It is
    // never consulted for hazards, because the register file writes in the
    // first half of the cycle and ID reads the new value in the second half.
    logic  unused_wb_slot;
    assign unused_wb_slot = ^wb_slot;

    // A source only takes part in hazard checks when the instruction is real,
    // actually reads that field, and the field is not $0 (hardwired zero).
    assign src_a_live = id_valid & r1_used & (id_rs != 5'd0);
    assign src_b_live = id_valid & r2_used & (id_rt != 5'd0);

    // Writes to $0 are discarded by the register file, so such a slot
    // produces nothing worth waiting for or forwarding.
    assign ex_writer  = ex_slot.valid  & (ex_slot.dest  != 5'd0);
    assign mem_writer = mem_slot.valid & (mem_slot.dest != 5'd0);

    assign match_ex_a  = src_a_live & ex_writer  & (ex_slot.dest  == id_rs);
    assign match_ex_b  = src_b_live & ex_writer  & (ex_slot.dest  == id_rt);
    assign match_mem_a = src_a_live & mem_writer & (mem_slot.dest == id_rs);
    assign match_mem_b = src_b_live & mem_writer & (mem_slot.dest == id_rt);

`ifdef HAZARD_FORWARDING_EN
    // With bypass paths, only a load in EX is too late: its data appears
    // at the end of MEM. So the dependent instruction waits exactly one cycle.
    assign hazard = ex_slot.is_load & (match_ex_a | match_ex_b);
`else
    // Without bypass paths, a result is visible to ID only once the writer
    // reaches WB. Any writer still in EX or MEM therefore blocks the read.
    assign hazard = match_ex_a | match_ex_b | match_mem_a | match_mem_b;
`endif

    // A redirect discards the ID instruction. There is nothing to hold, so
    // flush suppresses the stall but still forces the bubble.
    assign stall  = hazard & ~flush;
    assign bubble = hazard | flush;

    // The next EX slot carries the ID instruction's write intent unless
    // ID/EX is being cleared this cycle.
    always_comb begin
        ex_next = '0;
        if (!bubble) begin
            ex_next.valid   = id_valid & id_reg_write;
            ex_next.dest    = id_dest;
            ex_next.is_load = id_mem_to_reg;
        end
    end

    // Shadow pipeline advances on every edge, the same way the real stage
    // registers do. Stalls are handled by the bubble inserted into EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            ex_slot  <= ex_next;
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // The younger writer (EX) holds the most recent value of the register.
    // So it takes priority over an older MEM writer of the same register.
    always_comb begin
        sel_a = 2'd0;
        sel_b = 2'd0;
        if (match_ex_a) begin
            sel_a = 2'd1;
        end else if (match_mem_a) begin
            sel_a = 2'd2;
        end
        if (match_ex_b) begin
            sel_b = 2'd1;
        end else if (match_mem_b) begin
            sel_b = 2'd2;
        end
    end

    // The selects travel with the instruction into EX. A bubble becomes a
    // nop, so it must not drive a bypass mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= 2'd0;
            fwd_b <= 2'd0;
        end else if (bubble) begin
            fwd_a <= 2'd0;
            fwd_b <= 2'd0;
        end else begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end
    end
`else
    assign fwd_a = 2'd0;
    assign fwd_b = 2'd0;
`endif

    // Statistics. An event is counted on the first cycle of a stall run, so
    // the previous cycle's stall is remembered. Both counters stick at
    // all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            stall_events <= '0;
            prev_stall   <= 1'b0;
        end else begin
            prev_stall <= stall;
            if (stall && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (stall && !prev_stall && (stall_events != CNT_MAX)) begin
                stall_events <= stall_events + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit with CNT_W = 4.
// Expectations follow the build mode selected by HAZARD_FORWARDING_EN.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_SAT = 15;
`ifdef HAZARD_FORWARDING_EN
    localparam int STALLS_PER_DEP = 1;
`else
    localparam int STALLS_PER_DEP = 2;
`endif

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             r1_used;
    logic             r2_used;
    logic             id_reg_write;
    logic [4:0]       id_dest;
    logic             id_mem_to_reg;
    logic             flush;
    logic             stall;
    logic             bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] stall_events;

    int total;
    int bad;
    int exp_cycles;
    int exp_events;

    hazard_stall_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .r1_used       (r1_used),
        .r2_used       (r2_used),
        .id_reg_write  (id_reg_write),
        .id_dest       (id_dest),
        .id_mem_to_reg (id_mem_to_reg),
        .flush         (flush),
        .stall         (stall),
        .bubble        (bubble),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cycles  (stall_cycles),
        .stall_events  (stall_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID-stage instruction, then let the combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic r1, input logic r2, input logic wr,
                                 input logic [4:0] dest, input logic ld, input logic fl);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        r1_used       = r1;
        r2_used       = r2;
        id_reg_write  = wr;
        id_dest       = dest;
        id_mem_to_reg = ld;
        flush         = fl;
        #1;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock and sample well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_cycles"}, 32'(stall_cycles), 32'(exp_cycles));
        checkOutput({tag, "_events"}, 32'(stall_events), 32'(exp_events));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_cycles = 0;
        exp_events = 0;

        // Reset state
        rst_n = 1'b0;
        nop();
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_bubble", 32'(bubble), 32'd0);
        checkOutput("rst_fwd_a", 32'(fwd_a), 32'd0);
        checkOutput("rst_fwd_b", 32'(fwd_b), 32'd0);
        checkCounters("rst");
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("rst_flush_bubble", 32'(bubble), 32'd1);
        checkOutput("rst_flush_stall", 32'(stall), 32'd0);
        nop();
        step();
        rst_n = 1'b1;
        step();

        // $0 is never a hazard; unused sources are ignored
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        checkOutput("zero_wr_stall", 32'(stall), 32'd0);
        step();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        checkOutput("zero_src_stall", 32'(stall), 32'd0);
        checkOutput("zero_src_bubble", 32'(bubble), 32'd0);
        step();
        applyStimulus(1'b1, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("unused_src_stall", 32'(stall), 32'd0);
        checkOutput("zero_src_fwd_a", 32'(fwd_a), 32'd0);
        checkOutput("zero_src_fwd_b", 32'(fwd_b), 32'd0);
        step();
        nop();
        step();
        step();
        step();
        checkCounters("after_zero");

`ifndef HAZARD_FORWARDING_EN
        // add $8 ; beq $8,$0 -> two stall cycles, one event
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        checkOutput("nf_add_stall", 32'(stall), 32'd0);
        step();
        applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("nf_beq_stall1", 32'(stall), 32'd1);
        checkOutput("nf_beq_bubble1", 32'(bubble), 32'd1);
        step();
        checkOutput("nf_beq_stall2", 32'(stall), 32'd1);
        step();
        checkOutput("nf_beq_stall3", 32'(stall), 32'd0);
        checkOutput("nf_beq_bubble3", 32'(bubble), 32'd0);
        exp_cycles = 2;
        exp_events = 1;
        checkCounters("nf_beq");
        step();
        // writers $12,$13,$14 ; use $12 (3 ahead) -> none ; use $14 (2 ahead) -> one
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("nf_3ahead_stall", 32'(stall), 32'd0);
        step();
        applyStimulus(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("nf_2ahead_stall", 32'(stall), 32'd1);
        step();
        checkOutput("nf_2ahead_release", 32'(stall), 32'd0);
        checkOutput("nf_fwd_a_const", 32'(fwd_a), 32'd0);
        exp_cycles = 3;
        exp_events = 2;
        checkCounters("nf_2ahead");
        step();
`else
        // lw $8 ; add $9,$8,$10 -> one stall, then fwd_a = 2
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        checkOutput("fw_lw_stall", 32'(stall), 32'd0);
        step();
        applyStimulus(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        checkOutput("fw_lu_stall", 32'(stall), 32'd1);
        checkOutput("fw_lu_bubble", 32'(bubble), 32'd1);
        step();
        checkOutput("fw_lu_release", 32'(stall), 32'd0);
        checkOutput("fw_lu_bubble2", 32'(bubble), 32'd0);
        step();
        nop();
        checkOutput("fw_lu_fwd_a", 32'(fwd_a), 32'd2);
        checkOutput("fw_lu_fwd_b", 32'(fwd_b), 32'd0);
        exp_cycles = 1;
        exp_events = 1;
        checkCounters("fw_lu");
        step();
        // add $8 ; sub $9,$10,$8 -> no stall, fwd_b = 1
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd10, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        checkOutput("fw_alu_stall", 32'(stall), 32'd0);
        step();
        nop();
        checkOutput("fw_alu_fwd_a", 32'(fwd_a), 32'd0);
        checkOutput("fw_alu_fwd_b", 32'(fwd_b), 32'd1);
        step();
        // add $8 ; add $8 ; use $8 -> EX match beats MEM match
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        nop();
        checkOutput("fw_prio_fwd_a", 32'(fwd_a), 32'd1);
        checkOutput("fw_prio_fwd_b", 32'(fwd_b), 32'd0);
        step();
`endif

        // Load-use with flush: discard, no stall, EX slot invalid afterwards
        nop();
        step();
        step();
        step();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        checkOutput("flush_stall", 32'(stall), 32'd0);
        checkOutput("flush_bubble", 32'(bubble), 32'd1);
        step();
        applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("flush_next_stall", 32'(stall), 32'd0);
        checkOutput("flush_next_bubble", 32'(bubble), 32'd0);
        step();
        nop();
        checkOutput("flush_next_fwd_a", 32'(fwd_a), 32'd0);
        checkCounters("flush");
        step();
        step();
        step();

        // Saturation: repeat load-use dependencies until both counters pin at 15
        for (int it = 0; it < 16; it++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
            checkOutput("sat_lw_stall", 32'(stall), 32'd0);
            step();
            applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            for (int k = 0; k < STALLS_PER_DEP; k++) begin
                checkOutput("sat_use_stall", 32'(stall), 32'd1);
                step();
            end
            checkOutput("sat_use_release", 32'(stall), 32'd0);
            exp_cycles = (exp_cycles + STALLS_PER_DEP > CNT_SAT) ? CNT_SAT
                                                                 : exp_cycles + STALLS_PER_DEP;
            exp_events = (exp_events + 1 > CNT_SAT) ? CNT_SAT : exp_events + 1;
            checkCounters("sat_iter");
            step();
        end
        checkOutput("sat_cycles_final", 32'(stall_cycles), 32'd15);
        checkOutput("sat_events_final", 32'(stall_events), 32'd15);

        // Reset asserted mid-stall
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("mid_stall_before", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_stall", 32'(stall), 32'd0);
        checkOutput("mid_rst_bubble", 32'(bubble), 32'd0);
        exp_cycles = 0;
        exp_events = 0;
        checkCounters("mid_rst");
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_stall", 32'(stall), 32'd0);
        step();
        checkOutput("post_rst_stall2", 32'(stall), 32'd0);
        checkCounters("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
